// File: rtl/uart8_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart8_receiver_pkg
// Description : Shared UART state encoding. The transmitter uses the same
//               3-bit values, so both ends of a link decode identically.
// Revision    : 1.0 - initial release
// ============================================================================
package uart8_receiver_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int UART_STATE_W = 3;

    typedef logic [UART_STATE_W-1:0] uart_state_t;

    localparam uart_state_t RESET     = 3'd0;
    localparam uart_state_t IDLE      = 3'd1;
    localparam uart_state_t START_BIT = 3'd2;
    localparam uart_state_t DATA_BITS = 3'd3;
    localparam uart_state_t STOP_BIT  = 3'd4;

endpackage : uart8_receiver_pkg
`default_nettype wire

// File: rtl/uart8_receiver_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the asynchronous rx pin plus a
//               history flop for falling-edge detection.
// Ports       : clk   - sampling clock
//               rst   - synchronous active-high reset
//               din   - asynchronous serial line (idles high)
//               level - synchronized line level (resets high)
//               fall  - synchronized falling edge (resets low)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // All three flops reset to the idle (high) line level so that leaving
    // reset never fabricates an edge on a quiet line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_hist <= 1'b1;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign level = r_sync;
    assign fall  = r_hist & ~r_sync;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart8_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart8_receiver
// Description : 8N1 UART receiver, OVERSAMPLE clocks per bit. Detects the
//               start edge, confirms it at mid-start, samples each data bit
//               mid-bit (LSB first) and checks the stop bit.
// Ports       : clk  - oversampling clock (OVERSAMPLE x baud)
//               rst  - synchronous active-high reset
//               en   - arms reception (sampled only in IDLE)
//               in   - asynchronous rx line, idles high
//               out  - last correctly framed byte
//               done - one-cycle strobe, out updated
//               busy - frame in progress
//               err  - one-cycle strobe, stop bit sampled low
// Revision    : 1.0 - initial release
// ============================================================================
module uart8_receiver
    import uart8_receiver_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in,
    output logic [7:0] out,
    output logic       done,
    output logic       busy,
    output logic       err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);

    // Mid-start confirm point and end-of-bit (mid-bit after the half offset).
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(OVERSAMPLE - 1);

    logic                   w_line;
    logic                   w_fall;

    uart_state_t            r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [2:0]             r_bit_idx;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] r_out;
    logic                   r_done;
    logic                   r_busy;
    logic                   r_err;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (in),
        .level (w_line),
        .fall  (w_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RESET;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_out     <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Strobes are single-cycle by construction.
            r_done <= 1'b0;
            r_err  <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_busy    <= 1'b0;
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    // An edge is required: a line already low (break) is ignored.
                    if (en && w_fall) begin
                        r_state <= START_BIT;
                        r_busy  <= 1'b1;
                    end
                end

                START_BIT: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt <= '0;
                        // Line back high at mid-start means a glitch, not a frame.
                        r_state <= w_line ? IDLE : DATA_BITS;
                        if (w_line) begin
                            r_busy <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DATA_BITS: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_shift <= {w_line, r_shift[UART_DATA_W-1:1]};
                        if (&r_bit_idx) begin
                            r_state   <= STOP_BIT;
                            r_bit_idx <= '0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                STOP_BIT: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (w_line) begin
                            r_out  <= r_shift;
                            r_done <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // RESET and any undefined encoding recover through IDLE.
                default: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign done = r_done;
    assign busy = r_busy;
    assign err  = r_err;

endmodule : uart8_receiver
`default_nettype wire

// File: tb/tb_uart8_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart8_receiver
// Description : Directed self-checking bench for uart8_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart8_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       drv_line = 1'b1;
    logic       use_tx = 1'b0;
    wire        rx_line;
    logic [7:0] dut_out;
    logic       dut_done;
    logic       dut_busy;
    logic       dut_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Monitor state (written only by the monitor process).
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         busy_cnt = 0;
    int         last_done_cyc = -1;
    int         last_err_cyc  = -1;
    int         busy_rise_cyc = -1;
    logic       prev_busy = 1'b0;
    logic [7:0] out_log[$];

    // Behavioural transmitter for loopback.
    int         tx_req  = 0;
    int         tx_sent = 0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_line = 1'b1;
    logic       tx_busy = 1'b0;
    logic [9:0] tx_frame = '1;
    int         tx_div = 0;
    int         tx_bit = 0;

    assign rx_line = use_tx ? tx_line : drv_line;

    uart8_receiver #(.OVERSAMPLE(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .in   (rx_line),
        .out  (dut_out),
        .done (dut_done),
        .busy (dut_busy),
        .err  (dut_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dut_done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
            out_log.push_back(dut_out);
        end
        if (dut_err) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc;
        end
        if (dut_busy) busy_cnt <= busy_cnt + 1;
        if (dut_busy && !prev_busy) busy_rise_cyc <= cyc;
        prev_busy <= dut_busy;
    end

    always @(posedge clk) begin
        if (!tx_busy && tx_sent != tx_req) begin
            tx_busy  <= 1'b1;
            tx_frame <= {1'b1, tx_data, 1'b0};
            tx_div   <= 0;
            tx_bit   <= 0;
            tx_line  <= 1'b0;
        end else if (tx_busy) begin
            if (tx_div == 15) begin
                tx_div <= 0;
                if (tx_bit == 9) begin
                    tx_busy <= 1'b0;
                    tx_sent <= tx_sent + 1;
                    tx_line <= 1'b1;
                end else begin
                    tx_bit  <= tx_bit + 1;
                    tx_line <= tx_frame[tx_bit + 1];
                end
            end else begin
                tx_div <= tx_div + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame from the current cycle; c0 is the start-edge cycle.
    task automatic send_byte(input logic [7:0] data, input logic stop, output int c0);
        c0 = cyc;
        drv_line = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            drv_line = data[i];
            tick(16);
        end
        drv_line = stop;
        tick(16);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        checks++; if (dut_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", dut_out); end
        checks++; if (dut_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", dut_done); end
        checks++; if (dut_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", dut_busy); end
        checks++; if (dut_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", dut_err); end
        rst = 1'b0;
        tick(10);
    endtask

    task automatic test_clean_frame;
        int c0, d0, e0, b0;
        d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
        send_byte(8'hA5, 1'b1, c0);
        tick(5);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL clean_done_count: got %0d want 1", done_cnt - d0); end
        checks++; if (last_done_cyc !== c0 + 155) begin errors++; $display("FAIL clean_done_cycle: got %0d want %0d", last_done_cyc, c0 + 155); end
        checks++; if (dut_out !== 8'hA5) begin errors++; $display("FAIL clean_out: got %h want a5", dut_out); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL clean_err: got %0d want 0", err_cnt - e0); end
        checks++; if (busy_cnt - b0 !== 152) begin errors++; $display("FAIL clean_busy_len: got %0d want 152", busy_cnt - b0); end
        checks++; if (busy_rise_cyc !== c0 + 3) begin errors++; $display("FAIL clean_busy_rise: got %0d want %0d", busy_rise_cyc, c0 + 3); end
    endtask

    task automatic test_back_to_back;
        int c0, c1, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h00, 1'b1, c0);
        send_byte(8'hFF, 1'b1, c1);
        tick(5);
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
        checks++; if (out_log.size() < 2 || out_log[out_log.size()-2] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", out_log.size() >= 2 ? out_log[out_log.size()-2] : 8'hxx); end
        checks++; if (out_log.size() < 1 || out_log[out_log.size()-1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", out_log.size() >= 1 ? out_log[out_log.size()-1] : 8'hxx); end
        checks++; if (last_done_cyc !== c1 + 155) begin errors++; $display("FAIL b2b_done_cycle: got %0d want %0d", last_done_cyc, c1 + 155); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_glitch;
        int c0, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        tick(20);
        c0 = cyc;
        drv_line = 1'b0;
        tick(4);
        drv_line = 1'b1;
        tick(6);   // cycle c0+10 = detect+8
        checks++; if (dut_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_mid: got %b want 1", dut_busy); end
        tick(1);   // detect+9
        checks++; if (dut_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop: got %b want 0", dut_busy); end
        tick(200);
        checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_strobes: got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
        checks++; if (dut_out !== 8'hFF) begin errors++; $display("FAIL glitch_out: got %h want ff", dut_out); end
    endtask

    task automatic test_framing_error;
        int c0, c1, d0, e0, b0;
        d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
        send_byte(8'h3C, 1'b0, c0);
        tick(200);   // line held low (break)
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL ferr_err_count: got %0d want 1", err_cnt - e0); end
        checks++; if (last_err_cyc !== c0 + 155) begin errors++; $display("FAIL ferr_err_cycle: got %0d want %0d", last_err_cyc, c0 + 155); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL ferr_done: got %0d want 0", done_cnt - d0); end
        checks++; if (dut_out !== 8'hFF) begin errors++; $display("FAIL ferr_out: got %h want ff", dut_out); end
        checks++; if (busy_cnt - b0 !== 152) begin errors++; $display("FAIL ferr_break_busy: got %0d want 152", busy_cnt - b0); end
        drv_line = 1'b1;
        tick(20);
        d0 = done_cnt;
        send_byte(8'h81, 1'b1, c1);
        tick(5);
        checks++; if (done_cnt - d0 !== 1 || dut_out !== 8'h81) begin errors++; $display("FAIL ferr_recover: got done %0d out %h want 1 81", done_cnt - d0, dut_out); end
    endtask

    task automatic test_enable_reset;
        int c0, c1, d0, e0, b0;
        d0 = done_cnt; b0 = busy_cnt;
        en = 1'b0;
        send_byte(8'h77, 1'b1, c0);
        tick(20);
        checks++; if (done_cnt - d0 !== 0 || busy_cnt - b0 !== 0) begin errors++; $display("FAIL en_ignored: got done %0d busy %0d want 0 0", done_cnt - d0, busy_cnt - b0); end
        en = 1'b1;
        tick(5);
        // Start bit then all-ones data: no further falling edge after reset.
        d0 = done_cnt; e0 = err_cnt;
        drv_line = 1'b0;
        tick(16);
        drv_line = 1'b1;
        tick(64);
        checks++; if (dut_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", dut_busy); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (dut_out !== 8'h00 || dut_busy !== 1'b0 || dut_done !== 1'b0 || dut_err !== 1'b0) begin
            errors++; $display("FAIL rst_outputs: got out %h busy %b done %b err %b want 00 0 0 0", dut_out, dut_busy, dut_done, dut_err);
        end
        tick(150);
        checks++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin errors++; $display("FAIL rst_no_strobe: got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
        send_byte(8'h5A, 1'b1, c1);
        tick(5);
        checks++; if (done_cnt - d0 !== 1 || dut_out !== 8'h5A) begin errors++; $display("FAIL rst_next_frame: got done %0d out %h want 1 5a", done_cnt - d0, dut_out); end
    endtask

    task automatic test_loopback;
        logic [7:0] bytes [4];
        int d0, e0, t0, n0;
        bytes[0] = 8'h00; bytes[1] = 8'h55; bytes[2] = 8'hAA; bytes[3] = 8'hFF;
        d0 = done_cnt; e0 = err_cnt; t0 = tx_sent; n0 = out_log.size();
        use_tx = 1'b1;
        tick(5);
        for (int i = 0; i < 4; i++) begin
            tx_data = bytes[i];
            tx_req  = tx_req + 1;
            for (int k = 0; k < 400 && tx_sent != tx_req; k++) tick(1);
            checks++; if (tx_sent != tx_req) begin errors++; $display("FAIL loop_tx_timeout: got %0d want %0d", tx_sent, tx_req); end
        end
        tick(10);
        checks++; if (done_cnt - d0 !== tx_sent - t0) begin errors++; $display("FAIL loop_done_count: got %0d want %0d", done_cnt - d0, tx_sent - t0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_log.size() < n0 + 4 || out_log[n0 + i] !== bytes[i]) begin
                errors++; $display("FAIL loop_byte%0d: got %h want %h", i, out_log.size() > n0 + i ? out_log[n0 + i] : 8'hxx, bytes[i]);
            end
        end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL loop_err: got %0d want 0", err_cnt - e0); end
        use_tx = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_enable_reset();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart8_receiver
`default_nettype wire
